id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/ex_pkg.sv | 36 +++
 rtl/hazard_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 127 ++++++++++++
 tb/tb_id_ex_stage.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the ID/EX pipeline stage: ALU op codes, the register-zero
// constant and the packed control bundle carried from ID into EX.
package ex_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic [3:0] alu_op;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // A bubble carries no side effects: every control bit and the ALU op are zero.
  localparam ctrl_t CTRL_BUBBLE = ctrl_t'({CTRL_W{1'b0}});

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags when the instruction in ID reads the register
// that a load currently in EX has not yet produced.
module hazard_detect
  import ex_pkg::*;
(
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_dest_reg,
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  output logic       load_use
);

  logic live_load;
  logic rs_hit;
  logic rt_hit;

  // A load into register zero produces nothing a consumer could wait for.
  assign live_load = ex_valid & ex_mem_read & (ex_dest_reg != REG_ZERO);
  assign rs_hit    = (ex_dest_reg == id_rs);
  assign rt_hit    = id_uses_rt & (ex_dest_reg == id_rt);
  assign load_use  = live_load & (rs_hit | rt_hit) & id_valid;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash,
// memory-stall freeze and a saturating counter of load-use bubbles.
module id_ex_stage
  import ex_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic [3:0]        id_alu_op,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_alu_src,
  output logic [3:0]        ex_alu_op,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dest_reg,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic              stall_if_id,
  output logic [CNT_W-1:0]  stall_cnt
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  load_use;
  logic  insert_bubble;
  logic  count_bubble;

  assign id_ctrl = '{
    reg_write:  id_reg_write,
    mem_read:   id_mem_read,
    mem_write:  id_mem_write,
    mem_to_reg: id_mem_to_reg,
    alu_src:    id_alu_src,
    alu_op:     id_alu_op
  };

  hazard_detect u_hazard_detect (
    .ex_valid    (ex_valid),
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_dest_reg (ex_dest_reg),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use    (load_use)
  );

  // A flush squashes the dependent instruction anyway, so there is nothing to hold.
  assign stall_if_id   = (load_use & ~flush) | mem_stall;
  assign insert_bubble = flush | load_use | ~id_valid;
  assign count_bubble  = load_use & ~flush & ~mem_stall;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_ctrl     <= CTRL_BUBBLE;
      ex_rs       <= REG_ZERO;
      ex_rt       <= REG_ZERO;
      ex_dest_reg <= REG_ZERO;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
    end else if (!mem_stall) begin
      if (insert_bubble) begin
        ex_valid    <= 1'b0;
        ex_ctrl     <= CTRL_BUBBLE;
        ex_rs       <= REG_ZERO;
        ex_rt       <= REG_ZERO;
        ex_dest_reg <= REG_ZERO;
        ex_rs_data  <= '0;
        ex_rt_data  <= '0;
        ex_imm      <= '0;
      end else begin
        ex_valid    <= 1'b1;
        ex_ctrl     <= id_ctrl;
        ex_rs       <= id_rs;
        ex_rt       <= id_rt;
        ex_dest_reg <= id_reg_dst ? id_rd : id_rt;
        ex_rs_data  <= id_rs_data;
        ex_rt_data  <= id_rt_data;
        ex_imm      <= id_imm;
      end
    end
  end

  // Saturating: once all-ones the count sticks rather than wrapping to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (count_bubble && !(&stall_cnt)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign ex_reg_write  = ex_ctrl.reg_write;
  assign ex_mem_read   = ex_ctrl.mem_read;
  assign ex_mem_write  = ex_ctrl.mem_write;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_alu_op     = ex_ctrl.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a hand-computed vector table, directed
// corner sequences, and random traffic against a behavioural pipeline model.
module tb_id_ex_stage;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [4:0]        id_rs, id_rt, id_rd;
  logic              id_uses_rt;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic              id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [3:0]        id_alu_op;
  logic              flush, mem_stall;
  logic              ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src;
  logic [3:0]        ex_alu_op;
  logic [4:0]        ex_rs, ex_rt, ex_dest_reg;
  logic [DATA_W-1:0] ex_rs_data, ex_rt_data, ex_imm;
  logic              stall_if_id;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_mem_to_reg(id_mem_to_reg), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_alu_op(id_alu_op), .flush(flush), .mem_stall(mem_stall),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg), .ex_alu_src(ex_alu_src),
    .ex_alu_op(ex_alu_op), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest_reg(ex_dest_reg),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
    .stall_if_id(stall_if_id), .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic        valid;
    logic [4:0]  rs, rt, rd;
    logic        uses_rt;
    logic [31:0] rs_data, rt_data, imm;
    logic        reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst;
    logic [3:0]  alu_op;
    logic        flush, mem_stall;
  } stim_t;

  typedef struct packed {
    logic        valid, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
    logic [3:0]  alu_op;
    logic [4:0]  rs, rt, dest;
    logic [31:0] rs_data, rt_data, imm;
  } ex_t;

  typedef struct packed {
    stim_t      s;
    logic       exp_stall;
    logic       exp_valid;
    logic [4:0] exp_dest;
    logic       exp_mem_read;
    logic [3:0] exp_cnt;
  } vec_t;

  int unsigned tests = 0;
  int unsigned fails = 0;
  ex_t         m;
  int unsigned mcnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic stim_t mk_lw(input logic [4:0] rt, input logic [4:0] rs);
    stim_t s = '0;
    s.valid = 1'b1; s.rs = rs; s.rt = rt; s.reg_write = 1'b1; s.mem_read = 1'b1;
    s.mem_to_reg = 1'b1; s.alu_src = 1'b1; s.imm = 32'h0000_0010;
    s.rs_data = 32'h1000_0000 + 32'(rs); s.rt_data = 32'h2000_0000 + 32'(rt);
    return s;
  endfunction

  function automatic stim_t mk_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    stim_t s = '0;
    s.valid = 1'b1; s.rs = rs; s.rt = rt; s.rd = rd; s.uses_rt = 1'b1;
    s.reg_write = 1'b1; s.reg_dst = 1'b1; s.alu_op = 4'd0;
    s.rs_data = 32'hA000_0000 + 32'(rs); s.rt_data = 32'hB000_0000 + 32'(rt);
    return s;
  endfunction

  function automatic stim_t mk_addi(input logic [4:0] rt, input logic [4:0] rs);
    stim_t s = '0;
    s.valid = 1'b1; s.rs = rs; s.rt = rt; s.reg_write = 1'b1; s.alu_src = 1'b1;
    s.imm = 32'hFFFF_FFF0; s.rs_data = 32'hC000_0000 + 32'(rs);
    return s;
  endfunction

  // The ID instruction must wait if EX holds a valid load into a nonzero register it reads.
  function automatic bit model_hazard(input stim_t s);
    bit reads_it;
    reads_it = (m.dest == s.rs) || (s.uses_rt && m.dest == s.rt);
    return m.valid && m.mem_read && (m.dest != 5'd0) && s.valid && reads_it;
  endfunction

  task automatic model_apply(input stim_t s);
    bit hz;
    hz = model_hazard(s);
    if (!s.mem_stall) begin
      if (hz && !s.flush && mcnt < CNT_MAX) mcnt++;
      if (s.flush || hz || !s.valid) begin
        m = '0;
      end else begin
        m = '{valid: 1'b1, reg_write: s.reg_write, mem_read: s.mem_read, mem_write: s.mem_write,
              mem_to_reg: s.mem_to_reg, alu_src: s.alu_src, alu_op: s.alu_op,
              rs: s.rs, rt: s.rt, dest: (s.reg_dst ? s.rd : s.rt),
              rs_data: s.rs_data, rt_data: s.rt_data, imm: s.imm};
      end
    end
  endtask

  function automatic ex_t dut_ex();
    return '{valid: ex_valid, reg_write: ex_reg_write, mem_read: ex_mem_read, mem_write: ex_mem_write,
             mem_to_reg: ex_mem_to_reg, alu_src: ex_alu_src, alu_op: ex_alu_op,
             rs: ex_rs, rt: ex_rt, dest: ex_dest_reg,
             rs_data: ex_rs_data, rt_data: ex_rt_data, imm: ex_imm};
  endfunction

  task automatic drive(input stim_t s);
    id_valid = s.valid; id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; id_uses_rt = s.uses_rt;
    id_rs_data = s.rs_data; id_rt_data = s.rt_data; id_imm = s.imm;
    id_reg_write = s.reg_write; id_mem_read = s.mem_read; id_mem_write = s.mem_write;
    id_mem_to_reg = s.mem_to_reg; id_alu_src = s.alu_src; id_reg_dst = s.reg_dst;
    id_alu_op = s.alu_op; flush = s.flush; mem_stall = s.mem_stall;
  endtask

  task automatic check_state(input string tag);
    check({tag, " ex_regs"}, 128'(dut_ex()), 128'(m));
    check({tag, " stall_cnt"}, 128'(stall_cnt), 128'(mcnt));
  endtask

  // One pipeline cycle: drive at negedge, check stall before the edge, check EX after it.
  task automatic step(input stim_t s, input string tag, output logic seen_stall);
    bit exp_stall;
    @(negedge clk);
    drive(s);
    #1;
    exp_stall  = (model_hazard(s) && !s.flush) || s.mem_stall;
    seen_stall = stall_if_id;
    check({tag, " stall_if_id"}, 128'(stall_if_id), 128'(exp_stall));
    @(posedge clk);
    #1;
    model_apply(s);
    check_state(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive('0);
    repeat (2) @(posedge clk);
    #1;
    m = '0;
    mcnt = 0;
    check_state("reset");
    check("reset stall_if_id", 128'(stall_if_id), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    vec_t  vt[18];
    stim_t s;
    logic  st;
    int unsigned cnt_before;

    vt[0]  = '{mk_lw(5'd8, 5'd1),      1'b0, 1'b1, 5'd8,  1'b1, 4'd0};
    vt[1]  = '{mk_add(5'd9, 5'd8, 5'd3), 1'b1, 1'b0, 5'd0,  1'b0, 4'd1};
    vt[2]  = '{mk_add(5'd9, 5'd8, 5'd3), 1'b0, 1'b1, 5'd9,  1'b0, 4'd1};
    vt[3]  = '{mk_lw(5'd0, 5'd1),      1'b0, 1'b1, 5'd0,  1'b1, 4'd1};
    vt[4]  = '{mk_add(5'd9, 5'd0, 5'd3), 1'b0, 1'b1, 5'd9,  1'b0, 4'd1};
    vt[5]  = '{mk_lw(5'd5, 5'd2),      1'b0, 1'b1, 5'd5,  1'b1, 4'd1};
    s = mk_add(5'd9, 5'd5, 5'd3); s.flush = 1'b1;
    vt[6]  = '{s,                      1'b0, 1'b0, 5'd0,  1'b0, 4'd1};
    vt[7]  = '{mk_lw(5'd7, 5'd2),      1'b0, 1'b1, 5'd7,  1'b1, 4'd1};
    vt[8]  = '{mk_addi(5'd7, 5'd2),    1'b0, 1'b1, 5'd7,  1'b0, 4'd1};
    vt[9]  = '{mk_lw(5'd4, 5'd2),      1'b0, 1'b1, 5'd4,  1'b1, 4'd1};
    vt[10] = '{mk_add(5'd6, 5'd3, 5'd4), 1'b1, 1'b0, 5'd0,  1'b0, 4'd2};
    vt[11] = '{mk_add(5'd6, 5'd3, 5'd4), 1'b0, 1'b1, 5'd6,  1'b0, 4'd2};
    s = mk_add(5'd1, 5'd6, 5'd6); s.valid = 1'b0;
    vt[12] = '{s,                      1'b0, 1'b0, 5'd0,  1'b0, 4'd2};
    vt[13] = '{mk_lw(5'd8, 5'd1),      1'b0, 1'b1, 5'd8,  1'b1, 4'd2};
    vt[14] = '{mk_lw(5'd9, 5'd8),      1'b1, 1'b0, 5'd0,  1'b0, 4'd3};
    vt[15] = '{mk_lw(5'd9, 5'd8),      1'b0, 1'b1, 5'd9,  1'b1, 4'd3};
    vt[16] = '{mk_add(5'd10, 5'd9, 5'd0), 1'b1, 1'b0, 5'd0, 1'b0, 4'd4};
    vt[17] = '{mk_add(5'd10, 5'd9, 5'd0), 1'b0, 1'b1, 5'd10, 1'b0, 4'd4};

    rst_n = 1'b0;
    drive('0);
    do_reset();

    for (int i = 0; i < 18; i++) begin
      step(vt[i].s, $sformatf("vec%0d", i), st);
      check($sformatf("vec%0d tbl_stall", i),  128'(st),          128'(vt[i].exp_stall));
      check($sformatf("vec%0d tbl_valid", i),  128'(ex_valid),    128'(vt[i].exp_valid));
      check($sformatf("vec%0d tbl_dest", i),   128'(ex_dest_reg), 128'(vt[i].exp_dest));
      check($sformatf("vec%0d tbl_mread", i),  128'(ex_mem_read), 128'(vt[i].exp_mem_read));
      check($sformatf("vec%0d tbl_cnt", i),    128'(stall_cnt),   128'(vt[i].exp_cnt));
    end

    // Asynchronous reset between edges while EX holds a valid instruction.
    @(negedge clk);
    drive('0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst ex_valid", 128'(ex_valid), 128'(0));
    check("async_rst stall_cnt", 128'(stall_cnt), 128'(0));
    check("async_rst ex_regs", 128'(dut_ex()), 128'(ex_t'('0)));
    mem_stall = 1'b1;
    #1;
    check("rst mem_stall stall_if_id", 128'(stall_if_id), 128'(1));
    mem_stall = 1'b0;
    #1;
    check("rst idle stall_if_id", 128'(stall_if_id), 128'(0));
    m = '0;
    mcnt = 0;

    // Release reset between edges; the first edge must capture normally.
    s = mk_lw(5'd8, 5'd1);
    drive(s);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_apply(s);
    check_state("rst_release");
    check("rst_release valid", 128'(ex_valid), 128'(1));

    // Memory stall for three cycles on top of a pending load-use.
    cnt_before = mcnt;
    s = mk_add(5'd9, 5'd8, 5'd3);
    s.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(s, $sformatf("mstall%0d", i), st);
      check($sformatf("mstall%0d held_dest", i), 128'(ex_dest_reg), 128'(8));
      check($sformatf("mstall%0d held_mread", i), 128'(ex_mem_read), 128'(1));
      check($sformatf("mstall%0d cnt", i), 128'(stall_cnt), 128'(cnt_before));
    end
    s.mem_stall = 1'b0;
    step(s, "mstall_bubble", st);
    check("mstall_bubble stall", 128'(st), 128'(1));
    check("mstall_bubble valid", 128'(ex_valid), 128'(0));
    check("mstall_bubble cnt", 128'(stall_cnt), 128'(cnt_before + 1));
    step(s, "mstall_capture", st);
    check("mstall_capture dest", 128'(ex_dest_reg), 128'(9));

    // Saturation of the bubble counter.
    do_reset();
    for (int i = 0; i < CNT_MAX; i++) begin
      step(mk_lw(5'd8, 5'd1), "sat_lw", st);
      step(mk_add(5'd9, 5'd8, 5'd3), "sat_bub", st);
      step(mk_add(5'd9, 5'd8, 5'd3), "sat_cap", st);
    end
    check("sat reached", 128'(stall_cnt), 128'(CNT_MAX));
    step(mk_lw(5'd8, 5'd1), "sat_lw_last", st);
    step(mk_add(5'd9, 5'd8, 5'd3), "sat_bub_last", st);
    check("sat extra stall", 128'(st), 128'(1));
    check("sat held", 128'(stall_cnt), 128'(CNT_MAX));

    // Random traffic against the model; small register range provokes hazards.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      s = '0;
      s.valid      = ($urandom_range(7) != 0);
      s.rs         = 5'($urandom_range(3));
      s.rt         = 5'($urandom_range(3));
      s.rd         = 5'($urandom_range(3));
      s.uses_rt    = 1'($urandom_range(1));
      s.rs_data    = $urandom;
      s.rt_data    = $urandom;
      s.imm        = $urandom;
      s.reg_write  = 1'($urandom_range(1));
      s.mem_read   = 1'($urandom_range(1));
      s.mem_write  = 1'($urandom_range(1));
      s.mem_to_reg = 1'($urandom_range(1));
      s.alu_src    = 1'($urandom_range(1));
      s.reg_dst    = 1'($urandom_range(1));
      s.alu_op     = 4'($urandom_range(15));
      s.flush      = ($urandom_range(7) == 0);
      s.mem_stall  = ($urandom_range(5) == 0);
      step(s, $sformatf("rand%0d", i), st);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
